// File: rtl/md5_padder.sv
// MD5 message padder: packs 32-bit little-endian beats into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, one pulse per block.
module md5_padder (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [31:0]  data_i,
    input  logic         last_i,
    input  logic [2:0]   bytes_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [511:0] wb_o,
    output logic         last_o
);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_EXTRA = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_w;
    logic [60:0]    r_cnt;
    logic [31:0]    r_asm [16];
    logic           r_extra_p16;
    logic [511:0]   r_wb;
    logic           r_valid;
    logic           r_last;
    logic           r_ready;

    logic           w_acc;
    logic [2:0]     w_b;
    logic           w_b4;
    logic [31:0]    w_last_word;
    logic [31:0]    w_cur_word;
    logic [4:0]     w_p;
    logic [60:0]    w_cnt_new;
    logic [63:0]    w_len;
    logic [511:0]   w_data_blk;
    logic [511:0]   w_extra_blk;
    logic           w_len_fits;
    logic           w_emit;
    logic           w_emit_last;
    logic [511:0]   w_emit_blk;

    assign w_acc     = valid_i & r_ready;
    assign w_b4      = (w_b == 3'd4);
    assign w_p       = {1'b0, r_w} + {4'd0, w_b4};
    assign w_cnt_new = r_cnt + {58'd0, w_b};
    assign w_len     = {w_cnt_new, 3'b000};
    assign w_len_fits = (w_p <= 5'd13);
    assign w_cur_word = last_i ? w_last_word : data_i;

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign wb_o    = r_wb;
    assign last_o  = r_last;

    // Clamp byte count and build the tail word with its 0x80 marker
    always_comb begin
        w_last_word = 32'd0;
        if (bytes_i > 3'd4) begin
            w_b = 3'd4;
        end else begin
            w_b = bytes_i;
        end
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_b) begin
                w_last_word[8*k +: 8] = data_i[8*k +: 8];
            end else if (3'(k) == w_b) begin
                w_last_word[8*k +: 8] = 8'h80;
            end else begin
                w_last_word[8*k +: 8] = 8'h00;
            end
        end
    end

    // Block presented when the current beat closes a block (data or final)
    always_comb begin
        w_data_blk = 512'd0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < {1'b0, r_w}) begin
                w_data_blk[32*i +: 32] = r_asm[i];
            end else if (5'(i) == {1'b0, r_w}) begin
                w_data_blk[32*i +: 32] = w_cur_word;
            end else if (last_i && w_b4 && (5'(i) == w_p)) begin
                w_data_blk[32*i +: 32] = 32'h0000_0080;
            end else begin
                w_data_blk[32*i +: 32] = 32'd0;
            end
        end
        if (last_i && w_len_fits) begin
            w_data_blk[14*32 +: 32] = w_len[31:0];
            w_data_blk[15*32 +: 32] = w_len[63:32];
        end else begin
            w_data_blk[14*32 +: 32] = w_data_blk[14*32 +: 32];
        end
    end

    // Padding-only block; the byte counter already holds the full length here
    always_comb begin
        w_extra_blk = 512'd0;
        if (r_extra_p16) begin
            w_extra_blk[31:0] = 32'h0000_0080;
        end else begin
            w_extra_blk[31:0] = 32'd0;
        end
        w_extra_blk[14*32 +: 32] = {r_cnt[28:0], 3'b000};
        w_extra_blk[15*32 +: 32] = r_cnt[60:29];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: EXTRA only when the length no longer fits
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_acc && last_i && !w_len_fits) begin
                    w_next_state = ST_EXTRA;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_EXTRA: w_next_state = ST_FILL;
            default:  w_next_state = ST_FILL;
        endcase
    end

    // Output decode: which block to present next cycle and its last flag
    always_comb begin
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        w_emit_blk  = w_data_blk;
        case (r_state)
            ST_FILL: begin
                if (w_acc && last_i) begin
                    w_emit      = 1'b1;
                    w_emit_last = w_len_fits;
                end else if (w_acc && (r_w == 4'd15)) begin
                    w_emit      = 1'b1;
                    w_emit_last = 1'b0;
                end else begin
                    w_emit      = 1'b0;
                    w_emit_last = 1'b0;
                end
            end
            ST_EXTRA: begin
                w_emit      = 1'b1;
                w_emit_last = 1'b1;
                w_emit_blk  = w_extra_blk;
            end
            default: begin
                w_emit      = 1'b0;
                w_emit_last = 1'b0;
            end
        endcase
    end

    // Datapath: assembly buffer, word index, byte counter and output block
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w         <= 4'd0;
            r_cnt       <= 61'd0;
            r_extra_p16 <= 1'b0;
            r_wb        <= 512'd0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_ready     <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                r_asm[i] <= 32'd0;
            end
        end else begin
            r_valid <= w_emit;
            r_last  <= w_emit_last;
            r_ready <= (w_next_state == ST_FILL);
            if (w_emit) begin
                r_wb <= w_emit_blk;
            end
            if (r_state == ST_EXTRA) begin
                r_w   <= 4'd0;
                r_cnt <= 61'd0;
            end else if (w_acc && last_i) begin
                r_w         <= 4'd0;
                r_extra_p16 <= (w_p == 5'd16);
                if (w_len_fits) begin
                    r_cnt <= 61'd0;
                end else begin
                    r_cnt <= w_cnt_new;
                end
            end else if (w_acc) begin
                r_asm[r_w] <= data_i;
                r_cnt      <= r_cnt + 61'd4;
                r_w        <= r_w + 4'd1;
            end
        end
    end

endmodule
